// File: rtl/segrun_pkg.sv
// segrun_pkg: shared state type and default sizing for the runner display serialiser
package segrun_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_WIDTH = 6;
  localparam int DEF_DIV = 4;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/piso_shift_6b_if.sv
// piso_shift_6b_if: load handshake plus serial data/clock pair of the serialiser
interface piso_shift_6b_if import segrun_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic [WIDTH-1:0] LoadValue;
  logic Load, Ready, BitOut, ShiftOut, Busy, Done;
  logic [cnt_w(WIDTH)-1:0] BitsLeft;
  modport master (output LoadValue, Load, input Ready, BitOut, ShiftOut, Busy, Done, BitsLeft);
  modport slave (input LoadValue, Load, output Ready, BitOut, ShiftOut, Busy, Done, BitsLeft);
endinterface

// File: rtl/piso_shift_6b_bit_phase_ctr.sv
// bit_phase_ctr: DIV-modulo phase counter with a registered shift-clock level and end-of-bit strobe
module bit_phase_ctr import segrun_pkg::*; #(parameter int DIV = DEF_DIV) (
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  output logic lvl,
  output logic stb
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] cnt, cnt_n;
  assign cnt_n = cnt == PW'(DIV - 1) ? '0 : cnt + PW'(1);
  assign stb = en && cnt == PW'(DIV - 1);
  // level follows the next phase so the clock output comes straight from a flop
  always_ff @(posedge Clk) begin
    if (!Rst || !en) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else begin
      cnt <= cnt_n;
      lvl <= cnt_n >= PW'(DIV / 2);
    end
  end
endmodule

// File: rtl/piso_shift_6b.sv
// piso_shift_6b: parallel-in serial-out shifter driving MSB-first data with a mid-bit shift clock
module piso_shift_6b import segrun_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV = DEF_DIV
) (
  input logic Clk,
  input logic Rst,
  piso_shift_6b_if.slave bus
);
  localparam int BW = cnt_w(WIDTH);
  if (DIV < 2 || DIV % 2 != 0) begin : g_div_chk
    $error("DIV must be even and >= 2");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
    $error("WIDTH must be 2..16");
  end
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] bits_left;
  logic ready, busy, done, lvl, stb;
  bit_phase_ctr #(.DIV(DIV)) u_ctr (.Clk(Clk), .Rst(Rst), .en(state == SHIFT), .lvl(lvl), .stb(stb));
  // zero fill leaves sr clear in DONE and IDLE, so its MSB doubles as BitOut
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      sr <= '0;
      bits_left <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.Load) begin
          state <= SHIFT;
          sr <= bus.LoadValue;
          bits_left <= BW'(WIDTH);
          ready <= 1'b0;
          busy <= 1'b1;
        end
        SHIFT: if (stb) begin
          sr <= sr << 1;
          bits_left <= bits_left - BW'(1);
          if (bits_left == BW'(1)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.Ready = ready;
  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.BitOut = sr[WIDTH-1];
  assign bus.ShiftOut = lvl;
  assign bus.BitsLeft = bits_left;
endmodule

// File: tb/tb_piso_shift_6b.sv
// tb_piso_shift_6b: directed vector bench for the serialiser at 6b/DIV4 and 8b/DIV2
module tb_piso_shift_6b;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;
  piso_shift_6b_if #(.WIDTH(6)) b6 ();
  piso_shift_6b_if #(.WIDTH(8)) b8 ();
  piso_shift_6b #(.WIDTH(6), .DIV(4)) dut (.Clk(Clk), .Rst(Rst), .bus(b6));
  piso_shift_6b #(.WIDTH(8), .DIV(2)) dut8 (.Clk(Clk), .Rst(Rst), .bus(b8));
  logic [5:0] rx6 = '0;
  logic [7:0] rx8 = '0;
  int rise6 = 0;
  int rise8 = 0;
  int errs = 0;
  int checks = 0;
  always @(posedge b6.ShiftOut) begin
    rx6 <= {rx6[4:0], b6.BitOut};
    rise6 <= rise6 + 1;
  end
  always @(posedge b8.ShiftOut) begin
    rx8 <= {rx8[6:0], b8.BitOut};
    rise8 <= rise8 + 1;
  end
  typedef struct {
    logic [5:0] val;
    logic [5:0] intr;
    int intr_t;
    logic [5:0] exp_rx;
  } vec_t;
  vec_t tbl[3];
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic run6(input logic [5:0] v, input logic [5:0] intr, input int intr_t);
    b6.LoadValue = v;
    b6.Load = 1'b1;
    tick;
    b6.Load = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      if (t == intr_t) begin
        b6.LoadValue = intr;
        b6.Load = 1'b1;
      end
      if (t == intr_t + 1) b6.Load = 1'b0;
      chk($sformatf("w%b t%0d rdy/bsy/dn/sck/dat", v, t), {b6.Ready, b6.Busy, b6.Done, b6.ShiftOut, b6.BitOut},
          {3'b010, 1'(((t - 1) % 4) >= 2), v[5-(t-1)/4]});
      chk($sformatf("w%b t%0d bitsleft", v, t), b6.BitsLeft, 6 - (t - 1) / 4);
      tick;
    end
    chk($sformatf("w%b done cycle", v), {b6.Ready, b6.Busy, b6.Done, b6.ShiftOut, b6.BitOut, b6.BitsLeft}, 8'b011_00_000);
    tick;
    chk($sformatf("w%b ready cycle", v), {b6.Ready, b6.Busy, b6.Done, b6.ShiftOut, b6.BitOut, b6.BitsLeft}, 8'b100_00_000);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int r, n;
    logic [7:0] a5;
    tbl[0] = '{6'b101100, 6'b000000, 0, 6'b101100};
    tbl[1] = '{6'b111111, 6'b000001, 5, 6'b111111};
    tbl[2] = '{6'b010011, 6'b111000, 12, 6'b010011};
    b6.Load = 1'b1;
    b6.LoadValue = 6'h2A;
    b8.Load = 1'b1;
    b8.LoadValue = 8'hFF;
    Rst = 1'b0;
    repeat (3) begin
      tick;
      chk("reset6", {b6.Ready, b6.Busy, b6.Done, b6.ShiftOut, b6.BitOut, b6.BitsLeft}, 8'b100_00_000);
      chk("reset8", {b8.Ready, b8.Busy, b8.Done, b8.ShiftOut, b8.BitOut, b8.BitsLeft}, 9'b100_00_0000);
    end
    b6.Load = 1'b0;
    b8.Load = 1'b0;
    Rst = 1'b1;
    tick;
    chk("idle after release", {b6.Ready, b6.Busy, b6.Done, b6.ShiftOut, b6.BitOut, b6.BitsLeft}, 8'b100_00_000);
    for (int i = 0; i < 3; i++) begin
      r = rise6;
      run6(tbl[i].val, tbl[i].intr, tbl[i].intr_t);
      chk($sformatf("vec%0d receiver", i), rx6, tbl[i].exp_rx);
      chk($sformatf("vec%0d rises", i), rise6 - r, 6);
    end
    b6.LoadValue = 6'b010101;
    b6.Load = 1'b1;
    tick;
    for (int t = 1; t <= 24; t++) begin
      if (t == 10) b6.LoadValue = 6'b110011;
      tick;
    end
    chk("b2b first done", b6.Done, 1);
    chk("b2b first receiver", rx6, 6'b010101);
    tick;
    chk("b2b idle at E0+26", {b6.Ready, b6.Busy}, 2'b10);
    tick;
    chk("b2b second accept", {b6.Ready, b6.Busy, b6.BitsLeft}, 5'b01_110);
    b6.Load = 1'b0;
    n = 0;
    while (!b6.Done && n < 40) begin
      tick;
      n++;
    end
    chk("b2b second done latency", n, 24);
    chk("b2b second receiver", rx6, 6'b110011);
    tick;
    b6.LoadValue = 6'b100001;
    b6.Load = 1'b1;
    tick;
    b6.Load = 1'b0;
    repeat (9) tick;
    chk("midword busy", b6.Busy, 1);
    Rst = 1'b0;
    tick;
    chk("midword reset", {b6.Ready, b6.Busy, b6.Done, b6.ShiftOut, b6.BitOut, b6.BitsLeft}, 8'b100_00_000);
    Rst = 1'b1;
    r = rise6;
    repeat (30) tick;
    chk("midword no rises", rise6 - r, 0);
    chk("midword stays idle", {b6.Ready, b6.Busy, b6.BitsLeft}, 5'b10_000);
    a5 = 8'hA5;
    r = rise8;
    b8.LoadValue = a5;
    b8.Load = 1'b1;
    tick;
    b8.Load = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      chk($sformatf("w8 t%0d rdy/bsy/dn/sck/dat", t), {b8.Ready, b8.Busy, b8.Done, b8.ShiftOut, b8.BitOut},
          {3'b010, 1'(((t - 1) % 2) >= 1), a5[7-(t-1)/2]});
      chk($sformatf("w8 t%0d bitsleft", t), b8.BitsLeft, 8 - (t - 1) / 2);
      tick;
    end
    chk("w8 done at E0+17", {b8.Ready, b8.Busy, b8.Done, b8.ShiftOut, b8.BitOut, b8.BitsLeft}, 9'b011_00_0000);
    tick;
    chk("w8 ready at E0+18", {b8.Ready, b8.Busy, b8.Done}, 3'b100);
    chk("w8 receiver", rx8, 8'hA5);
    chk("w8 rises", rise8 - r, 8);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
